// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: MIPS fetch FSM (FETCH/DELIVER/ERROR) with PC sequencing, jump/branch select and retire count.
// Define FETCH_ALIGN_CHECK_EN to trap a misaligned next PC into a sticky ERROR state.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        Branch,
    input  logic [31:0] branch_target,
    input  logic        Jump,
    input  logic [25:0] jump_index,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic [15:0] instr_count,
    output logic        misalign_err
);
    typedef enum logic [1:0] {FETCH, DELIVER, ERROR} state_t;
    state_t      r_state;
    logic [31:0] r_pc, r_pc_out, r_instr;
    logic        r_valid, r_req, r_err;
    logic [15:0] r_count;
    logic [31:0] w_next, w_next_pc;
    logic        w_misalign;
    assign pc_plus4     = r_pc_out + 32'd4;
    assign w_next       = Jump ? {pc_plus4[31:28], jump_index, 2'b00} : Branch ? branch_target : pc_plus4;
`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misalign   = |w_next[1:0];
    assign w_next_pc    = w_next;
`else
    assign w_misalign   = 1'b0;
    assign w_next_pc    = w_next & ~32'd3;
`endif
    assign imem_req     = r_req;
    assign imem_addr    = r_pc;
    assign instr        = r_instr;
    assign opcode       = r_instr[31:26];
    assign funct        = r_instr[5:0];
    assign instr_valid  = r_valid;
    assign pc_out       = r_pc_out;
    assign instr_count  = r_count;
    assign misalign_err = r_err;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_pc_out <= RESET_PC;
            r_instr  <= '0;
            r_valid  <= 1'b0;
            r_req    <= 1'b0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    // An ack only counts against a request we are actually driving
                    if (r_req && imem_ack) begin
                        r_instr  <= imem_rdata;
                        r_pc_out <= r_pc;
                        r_valid  <= 1'b1;
                        r_req    <= 1'b0;
                        r_state  <= DELIVER;
                    end else begin
                        r_req    <= 1'b1;
                    end
                end
                DELIVER: begin
                    if (!stall) begin
                        r_valid <= 1'b0;
                        if (w_misalign) begin
                            r_err   <= 1'b1;
                            r_state <= ERROR;
                        end else begin
                            r_pc    <= w_next_pc;
                            r_count <= r_count + 16'd1;
                            r_req   <= 1'b1;
                            r_state <= FETCH;
                        end
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/mips_fetch_unit.md
MIPS_FETCH_UNIT -- requirements
Module: mips_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first instruction address fetched after reset.
REQ-002 SHALL use one clock; reset is synchronous and active-low.
REQ-003 SHALL have port clk, input, 1, system clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-005 SHALL have port stall, input, 1, downstream hold; when high, the delivered instruction is kept.
REQ-006 SHALL have port Branch, input, 1, branch taken; this is the decoded Branch qualified by the ALU zero result.
REQ-007 SHALL have port branch_target, input, 32, byte address used when Branch is applied.
REQ-008 SHALL have port Jump, input, 1, jump decoded for the delivered instruction.
REQ-009 SHALL have port jump_index, input, 26, instr_index field of J-type instructions.
REQ-010 SHALL have port imem_req, output, 1, instruction memory read request.
REQ-011 SHALL have port imem_addr, output, 32, instruction memory byte address.
REQ-012 SHALL have port imem_ack, input, 1, imem_rdata valid this cycle.
REQ-013 SHALL have port imem_rdata, input, 32, instruction word.
REQ-014 SHALL have port instr, output, 32, registered instruction.
REQ-015 SHALL have port opcode, output, 6, instr[31:26], which feeds the control unit opcode input.
REQ-016 SHALL have port funct, output, 6, instr[5:0], which feeds the control unit funct input.
REQ-017 SHALL have port instr_valid, output, 1, instr/opcode/funct are valid.
REQ-018 SHALL have port pc_out, output, 32, address of the delivered instruction.
REQ-019 SHALL have port pc_plus4, output, 32, pc_out + 4, combinational from pc_out.
REQ-020 SHALL have port instr_count, output, 16, number of instructions retired from DELIVER, wrapping modulo 2^16.
REQ-021 SHALL have port misalign_err, output, 1, sticky misaligned-target error.

Function
REQ-022 SHALL implement the states FETCH, DELIVER and ERROR.
REQ-023 In FETCH, the block SHALL:
- drive imem_req=1 and imem_addr=pc;
- hold imem_addr stable until imem_ack;
- on imem_ack, capture imem_rdata into instr and go to DELIVER;
- produce instr_valid=1 the cycle after the ack (minimum 2 cycles per instruction).
REQ-024 SHALL ignore imem_ack whenever imem_req=0.
REQ-025 In DELIVER with stall=1, the block SHALL hold instr, pc_out and instr_valid=1, keep imem_req=0, and ignore Branch/Jump.
REQ-026 In DELIVER with stall=0, the block SHALL load next pc, increment instr_count, clear instr_valid and go to FETCH.
REQ-027 Next pc SHALL be, in priority order:
- Jump=1: {pc_plus4[31:28], jump_index, 2'b00};
- else Branch=1: branch_target;
- else: pc_plus4.
REQ-028 Branch and Jump SHALL be sampled only in DELIVER with stall=0; there is no branch delay slot.
REQ-029 PC arithmetic SHALL be 32-bit modulo 2^32 (pc 32'hFFFF_FFFC + 4 = 32'h0000_0000).
REQ-030 pc_out SHALL equal the address the current instr was fetched from.

Reset
REQ-031 While rst_n=0 at a clock edge, the block SHALL set:
- pc=RESET_PC, pc_out=RESET_PC;
- instr=0, instr_valid=0, imem_req=0;
- instr_count=0, misalign_err=0;
- state=FETCH.
REQ-032 Reset mid-fetch SHALL abandon the outstanding request, and any later ack for it SHALL be ignored per REQ-024.
REQ-033 After reset is released, the first cycle SHALL drive imem_req=1 with imem_addr=RESET_PC.

Configuration
REQ-034 Macro FETCH_ALIGN_CHECK_EN defined: if the next pc selected in REQ-027 has bits [1:0]!=0, the block SHALL enter ERROR.
REQ-035 In ERROR, the block SHALL hold imem_req=0, instr_valid=0 and misalign_err=1 until reset, and instr_count SHALL not increment for the offending transition.
REQ-036 Macro FETCH_ALIGN_CHECK_EN undefined: next pc bits [1:0] SHALL be forced to 2'b00, ERROR SHALL be unreachable, and misalign_err SHALL be tied 0.

Verification
REQ-037 Sequential fetch: reset with RESET_PC=0, memory acks in the same cycle, stall=0 -> imem_addr sequence 0,4,8,12, instr_valid every other cycle, instr_count=4 after four retires.
REQ-038 Wait states and stall:
- stimulus: ack delayed 3 cycles, then stall=1 for 5 cycles at DELIVER;
- response: imem_addr stable across the wait, instr/pc_out held for 5 cycles, no new imem_req.
REQ-039 Jump priority: pc_out=32'h1000_0040, Jump=1, jump_index=26'h0000100, Branch=1, branch_target=32'h0000_0080 -> next imem_addr=32'h1000_0400.
REQ-040 Branch and decode fields:
- stimulus: Branch=1, branch_target=32'h0000_0200, then rdata=32'h0043_0820;
- response: imem_addr=32'h0000_0200, opcode=6'h00, funct=6'h20.
REQ-041 Reset mid-wait:
- stimulus: rst_n=0 while imem_req=1, then ack pulses with imem_req=0;
- response: all outputs at reset values, ack ignored, first fetch at RESET_PC.
REQ-042 Misaligned branch target, branch_target=32'h0000_0102:
- with FETCH_ALIGN_CHECK_EN defined: misalign_err=1, imem_req=0 until reset;
- with FETCH_ALIGN_CHECK_EN undefined: next imem_addr=32'h0000_0100, misalign_err=0.
